dotp_job_scheduler: RTL and testbench

DOTP_JOB_SCHEDULER -- requirements
Module: dotp_job_scheduler

---
 rtl/dotp_job_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_dotp_job_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dotp_job_scheduler.sv
// dotp_job_scheduler
//   Queues dot-product job descriptors in a small FIFO and hands them, one at
//   a time and strictly in arrival order, to a dot-product controller.
//
//   Ports
//     clk, rst                     clock (rising edge), async active-low reset
//     job_valid / job_ready        descriptor push handshake
//     job_a_addr, job_b_addr,
//     job_out_addr, job_len        descriptor being pushed
//     ctl_start                    one-cycle launch pulse to the controller
//     ctl_a_addr, ctl_b_addr,
//     ctl_out_addr, ctl_len        descriptor of the active job
//     ctl_done                     controller completion pulse
//     busy                         scheduler has an active or queued job
//     fifo_count                   number of queued descriptors
//     jobs_done                    completed-job counter (wraps)
//     timeout_err                  sticky: a job was aborted by the watchdog
//     err_clr                      clears timeout_err
module dotp_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [31:0]              job_a_addr,
  input  logic [31:0]              job_b_addr,
  input  logic [31:0]              job_out_addr,
  input  logic [31:0]              job_len,
  output logic                     ctl_start,
  output logic [31:0]              ctl_a_addr,
  output logic [31:0]              ctl_b_addr,
  output logic [31:0]              ctl_out_addr,
  output logic [31:0]              ctl_len,
  input  logic                     ctl_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              jobs_done,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [31:0] aAddr;
    logic [31:0] bAddr;
    logic [31:0] outAddr;
    logic [31:0] len;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP
  } state_t;

  desc_t           mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q;
  logic [PW-1:0]   rdPtr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  state_t          state_q;
  logic [TW-1:0]   waitTimer_q;
  desc_t           ctlDesc_q;
  logic            ctlStart_q;
  logic [15:0]     jobsDone_q;
  logic            timeoutErr_q;

  logic            push;
  logic            pop;
  desc_t           jobDesc;
  desc_t           headDesc;

  // Handshake and FIFO head. A pop only happens from IDLE, so the FSM and the
  // pointer logic agree on exactly when the head leaves the queue.
  assign jobDesc   = {job_a_addr, job_b_addr, job_out_addr, job_len};
  assign headDesc  = mem_q[rdPtr_q];
  assign job_ready = (count_q < CW'(DEPTH));
  assign push      = job_valid && job_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);

  // Occupancy next-state: a push and a pop on the same edge cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Descriptor storage. No reset needed: the pointers and count decide what
  // is valid, and a reset empties the queue by clearing those.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= jobDesc;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Job sequencing FSM. ctl_start is registered out of LAUNCH, so it is high
  // during the first WAIT cycle. Zero-length jobs skip the controller and
  // count as done straight away. A timeout on the same edge as err_clr wins
  // because its assignment comes later in the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      waitTimer_q  <= '0;
      ctlDesc_q    <= '0;
      ctlStart_q   <= 1'b0;
      jobsDone_q   <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      ctlStart_q <= 1'b0;
      if (err_clr) begin
        timeoutErr_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pop) begin
            ctlDesc_q <= headDesc;
            if (headDesc.len == '0) begin
              jobsDone_q <= jobsDone_q + 16'd1;
              state_q    <= GAP;
            end else begin
              state_q <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          ctlStart_q  <= 1'b1;
          waitTimer_q <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (ctl_done) begin
            jobsDone_q <= jobsDone_q + 16'd1;
            state_q    <= GAP;
          end else if (waitTimer_q == TW'(TIMEOUT - 1)) begin
            timeoutErr_q <= 1'b1;
            state_q      <= GAP;
          end else begin
            waitTimer_q <= waitTimer_q + TW'(1);
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ctl_start    = ctlStart_q;
  assign ctl_a_addr   = ctlDesc_q.aAddr;
  assign ctl_b_addr   = ctlDesc_q.bAddr;
  assign ctl_out_addr = ctlDesc_q.outAddr;
  assign ctl_len      = ctlDesc_q.len;
  assign fifo_count   = count_q;
  assign jobs_done    = jobsDone_q;
  assign timeout_err  = timeoutErr_q;
  assign busy         = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_dotp_job_scheduler.sv
// tb_dotp_job_scheduler
//   Self-checking bench for dotp_job_scheduler (DEPTH 4, TIMEOUT 16).
//   Inputs change on the falling edge and outputs are sampled there too,
//   half a cycle away from the rising edge the design uses.
module tb_dotp_job_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_a_addr;
  logic [31:0] job_b_addr;
  logic [31:0] job_out_addr;
  logic [31:0] job_len;
  logic        ctl_start;
  logic [31:0] ctl_a_addr;
  logic [31:0] ctl_b_addr;
  logic [31:0] ctl_out_addr;
  logic [31:0] ctl_len;
  logic        ctl_done;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [15:0] jobs_done;
  logic        timeout_err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] aAddr;
    logic [31:0] bAddr;
    logic [31:0] outAddr;
    logic [31:0] len;
    int          doneDelay;
    logic        expStart;
    int          expDelta;
    logic        expErr;
  } vec_t;

  dotp_job_scheduler #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_a_addr   (job_a_addr),
    .job_b_addr   (job_b_addr),
    .job_out_addr (job_out_addr),
    .job_len      (job_len),
    .ctl_start    (ctl_start),
    .ctl_a_addr   (ctl_a_addr),
    .ctl_b_addr   (ctl_b_addr),
    .ctl_out_addr (ctl_out_addr),
    .ctl_len      (ctl_len),
    .ctl_done     (ctl_done),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .jobs_done    (jobs_done),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: bumps the counters and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Presents one descriptor for a single clock, starting on a falling edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] o, input logic [31:0] len);
    job_a_addr   = a;
    job_b_addr   = b;
    job_out_addr = o;
    job_len      = len;
    job_valid    = 1'b1;
    @(negedge clk);
    job_valid    = 1'b0;
  endtask

  // One-cycle completion pulse from the controller.
  task automatic pulseDone();
    ctl_done = 1'b1;
    @(negedge clk);
    ctl_done = 1'b0;
  endtask

  // Safety net in case the design never lets the sequence progress.
  initial begin
    #300000;
    errors++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vec_t        vecs[6];
    vec_t        v;
    logic [15:0] expJobs;
    logic        prevErr;
    int          n;
    int          startSeen;
    int          expCnt[5];

    vecs[0] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'd8,         10, 1'b1, 1, 1'b0};
    vecs[1] = '{32'h0000_1100, 32'h0000_2100, 32'h0000_3100, 32'd1,          0, 1'b1, 1, 1'b0};
    vecs[2] = '{32'h0000_1200, 32'h0000_2200, 32'h0000_3200, 32'd0,          0, 1'b0, 1, 1'b0};
    vecs[3] = '{32'h0000_1300, 32'h0000_2300, 32'h0000_3300, 32'd4,         15, 1'b1, 1, 1'b0};
    vecs[4] = '{32'h0000_1400, 32'h0000_2400, 32'h0000_3400, 32'd3,         -1, 1'b1, 0, 1'b1};
    vecs[5] = '{32'h0000_1500, 32'h0000_2500, 32'h0000_3500, 32'hFFFF_FFFF,  2, 1'b1, 1, 1'b1};
    expCnt  = '{1, 1, 2, 3, 4};

    rst          = 1'b1;
    job_valid    = 1'b0;
    job_a_addr   = '0;
    job_b_addr   = '0;
    job_out_addr = '0;
    job_len      = '0;
    ctl_done     = 1'b0;
    err_clr      = 1'b0;

    // Reset is asynchronous: outputs must settle before any clock edge.
    #1 rst = 1'b0;
    #1;
    checkOutput("reset fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("reset job_ready", 32'(job_ready), 32'd1);
    checkOutput("reset ctl_start", 32'(ctl_start), 32'd0);
    checkOutput("reset ctl_len", ctl_len, 32'd0);
    checkOutput("reset jobs_done", 32'(jobs_done), 32'd0);
    checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table of single jobs pushed into an idle scheduler.
    expJobs = 16'd0;
    prevErr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      checkOutput($sformatf("v%0d job_ready", i), 32'(job_ready), 32'd1);
      applyStimulus(v.aAddr, v.bAddr, v.outAddr, v.len);
      @(negedge clk);
      checkOutput($sformatf("v%0d ctl_start early", i), 32'(ctl_start), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d ctl_start", i), 32'(ctl_start), 32'(v.expStart));
      if (v.expStart) begin
        checkOutput($sformatf("v%0d ctl_a_addr", i), ctl_a_addr, v.aAddr);
        checkOutput($sformatf("v%0d ctl_b_addr", i), ctl_b_addr, v.bAddr);
        checkOutput($sformatf("v%0d ctl_out_addr", i), ctl_out_addr, v.outAddr);
        checkOutput($sformatf("v%0d ctl_len", i), ctl_len, v.len);
        if (v.doneDelay >= 0) begin
          repeat (v.doneDelay) @(negedge clk);
          pulseDone();
        end else begin
          repeat (TIMEOUT - 1) @(negedge clk);
          checkOutput($sformatf("v%0d err before timeout", i), 32'(timeout_err), 32'(prevErr));
          @(negedge clk);
        end
        checkOutput($sformatf("v%0d busy in gap", i), 32'(busy), 32'd1);
        @(negedge clk);
      end
      expJobs = expJobs + 16'(v.expDelta);
      prevErr = v.expErr;
      checkOutput($sformatf("v%0d jobs_done", i), 32'(jobs_done), 32'(expJobs));
      checkOutput($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(v.expErr));
      checkOutput($sformatf("v%0d busy idle", i), 32'(busy), 32'd0);
    end

    // Clear the sticky error.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err_clr clears", 32'(timeout_err), 32'd0);

    // Timeout and err_clr on the same edge: the timeout must win.
    applyStimulus(32'h0000_1600, 32'h0000_2600, 32'h0000_3600, 32'd2);
    repeat (2) @(negedge clk);
    err_clr = 1'b1;
    repeat (TIMEOUT) @(negedge clk);
    checkOutput("timeout beats err_clr", 32'(timeout_err), 32'd1);
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("timeout jobs_done", 32'(jobs_done), 32'(expJobs));
    checkOutput("timeout busy", 32'(busy), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err_clr second", 32'(timeout_err), 32'd0);

    // ctl_done while idle must not count.
    ctl_done = 1'b1;
    repeat (2) @(negedge clk);
    ctl_done = 1'b0;
    @(negedge clk);
    checkOutput("stray done ignored", 32'(jobs_done), 32'(expJobs));

    // Fill the queue behind a stalled controller; the sixth push is held.
    for (int k = 0; k < 5; k++) begin
      job_a_addr   = 32'hA000_0000 + 32'(k * 256);
      job_b_addr   = 32'hB000_0000 + 32'(k * 256);
      job_out_addr = 32'hC000_0000 + 32'(k * 256);
      job_len      = 32'(k + 1);
      job_valid    = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("fill%0d fifo_count", k), 32'(fifo_count), 32'(expCnt[k]));
      if (k == 2) begin
        checkOutput("fill j0 ctl_start", 32'(ctl_start), 32'd1);
        checkOutput("fill j0 ctl_a_addr", ctl_a_addr, 32'hA000_0000);
      end
    end
    job_a_addr   = 32'hA000_0500;
    job_b_addr   = 32'hB000_0500;
    job_out_addr = 32'hC000_0500;
    job_len      = 32'd6;
    checkOutput("full job_ready", 32'(job_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("full held count", 32'(fifo_count), 32'd4);
    checkOutput("full held ready", 32'(job_ready), 32'd0);
    pulseDone();
    checkOutput("full ready gap", 32'(job_ready), 32'd0);
    @(negedge clk);
    checkOutput("full ready idle", 32'(job_ready), 32'd0);
    @(negedge clk);
    checkOutput("after pop count", 32'(fifo_count), 32'd3);
    checkOutput("after pop ready", 32'(job_ready), 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
    checkOutput("held job accepted", 32'(fifo_count), 32'd4);
    checkOutput("j1 ctl_start", 32'(ctl_start), 32'd1);
    checkOutput("j1 ctl_a_addr", ctl_a_addr, 32'hA000_0100);
    expJobs = expJobs + 16'd1;
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      pulseDone();
      expJobs   = expJobs + 16'd1;
      n         = 0;
      startSeen = 0;
      while (n < 10 && startSeen == 0) begin
        @(negedge clk);
        n++;
        if (ctl_start) startSeen = 1;
      end
      checkOutput($sformatf("j%0d launch spacing", k), 32'(n), 32'd3);
      checkOutput($sformatf("j%0d ctl_a_addr", k), ctl_a_addr, 32'hA000_0000 + 32'(k * 256));
    end
    @(negedge clk);
    pulseDone();
    expJobs = expJobs + 16'd1;
    @(negedge clk);
    checkOutput("queue drained busy", 32'(busy), 32'd0);
    checkOutput("queue drained jobs_done", 32'(jobs_done), 32'(expJobs));

    // Reset during WAIT with two descriptors queued.
    job_len   = 32'd5;
    job_valid = 1'b1;
    repeat (3) @(negedge clk);
    job_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset count", 32'(fifo_count), 32'd2);
    #2 rst = 1'b0;
    #1;
    checkOutput("midjob reset count", 32'(fifo_count), 32'd0);
    checkOutput("midjob reset busy", 32'(busy), 32'd0);
    checkOutput("midjob reset ctl_a_addr", ctl_a_addr, 32'd0);
    checkOutput("midjob reset ctl_len", ctl_len, 32'd0);
    checkOutput("midjob reset jobs_done", 32'(jobs_done), 32'd0);
    checkOutput("midjob reset ready", 32'(job_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    startSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ctl_start) startSeen++;
    end
    checkOutput("no launch after reset", 32'(startSeen), 32'd0);
    checkOutput("idle after reset", 32'(busy), 32'd0);

    // jobs_done wraps from 0xFFFF to 0.
    force dut.jobsDone_q = 16'hFFFF;
    @(negedge clk);
    release dut.jobsDone_q;
    @(negedge clk);
    checkOutput("preload jobs_done", 32'(jobs_done), 32'h0000_FFFF);
    applyStimulus(32'h0000_1700, 32'h0000_2700, 32'h0000_3700, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("jobs_done wrap", 32'(jobs_done), 32'd0);
    checkOutput("wrap busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
